itof_pipe: RTL
==============

ITOF_PIPE -- requirements
Module: itof_pipe

Interface
REQ-001 Parameter IN_WIDTH, default 32, integer operand width; legal range 8..64.
REQ-002 Parameter STAGES, default 2, register stages from input to output; legal values 1, 2, 3.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand present.
REQ-006 in_ready  output  1  block accepts operand this cycle.
REQ-007 x  input  IN_WIDTH  integer operand.
REQ-008 is_unsigned  input  1  1: x is unsigned; 0: x is two's complement.
REQ-009 rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 y  output  32  IEEE-754 binary32 result.
REQ-013 inexact  output  1  result differs from exact value of x.

Function
REQ-014 Transfer occurs on in_valid && in_ready (input) and on out_valid && out_ready (output); x, is_unsigned and rm are sampled only at input transfer.
REQ-015 y SHALL equal the correctly rounded binary32 value of x under rm; for RNE, y SHALL be bit-identical to a simulator int-to-shortreal conversion.
REQ-016 x == 0 SHALL give y = 0x00000000 (+0) in every mode; inexact = 0.
REQ-017 Signed most-negative value (-2^(IN_WIDTH-1)) SHALL convert without overflow of the magnitude path; for IN_WIDTH = 32, y = 0xCF000000, inexact = 0.
REQ-018 Magnitude with up to 24 significant bits is exact; inexact = 0.
REQ-019 Rounding carry-out of the mantissa SHALL increment the exponent (e.g. unsigned 0xFFFFFFFF RNE -> 0x4F800000).
REQ-020 Exponent = 127 + index of leading one; no overflow, NaN or denormal is reachable for legal IN_WIDTH.
REQ-021 Latency: with out_ready held high, a result appears on out_valid exactly STAGES cycles after its input transfer; throughput one per cycle.
REQ-022 Pipeline is elastic: each stage holds a valid bit; a stage advances when its successor is empty or transferring in the same cycle.
REQ-023 in_ready = stage 1 empty, or stage 1 advancing this cycle; in_ready MAY depend combinationally on out_ready.
REQ-024 Simultaneous input and output transfer on a full pipeline SHALL lose nothing and duplicate nothing.
REQ-025 While out_valid && !out_ready, y and inexact SHALL be held stable.
REQ-026 Results leave in input order; no reordering, no drops.
REQ-027 Stage split for STAGES = 2: stage 1 = sign capture, absolute value, leading-zero count; stage 2 = normalise, round, pack. STAGES = 1 registers only the output; STAGES = 3 registers additionally after normalise.

Reset
REQ-028 When rst is high at a clock edge, all stage valid bits SHALL clear; out_valid = 0 from the next cycle.
REQ-029 After reset, y = 0 and inexact = 0; in_ready = 1 in the first cycle rst is low.
REQ-030 Reset mid-stream SHALL discard all in-flight operands; no result of a pre-reset operand is ever emitted.
REQ-031 An input presented in a cycle with rst high is not accepted.

Structure
REQ-032 Package itof_pkg: rounding-mode enum (RNE, RTZ, RDN, RUP), binary32 field widths, exponent bias 127.
REQ-033 Sub-module lzc, parametrised by width, returns leading-zero count and all-zero flag; instantiated once in stage 1.
REQ-034 Round decision (guard, round, sticky, sign, rm -> increment) is a single function in itof_pkg.

Verification
REQ-035 x = 1, signed, RNE -> y = 0x3F800000, inexact = 0, after exactly STAGES cycles.
REQ-036 x = 0x01000001 signed: RNE -> 0x4B800000 inexact 1; RUP -> 0x4B800001; RTZ -> 0x4B800000.
REQ-037 x = 0x80000000 signed RNE -> 0xCF000000 inexact 0; x = -(2^24+1) RDN -> 0xCB800001 inexact 1.
REQ-038 x = 0xFFFFFFFF unsigned: RNE -> 0x4F800000; RTZ -> 0x4F7FFFFF; both inexact 1.
REQ-039 Stream 1000 random operands with random out_ready duty 30% -> every result matches reference model in order, y stable while stalled, no loss.
REQ-040 Fill pipeline, assert rst one cycle mid-stream -> out_valid = 0 next cycle, no stale result afterward; repeat sweep for IN_WIDTH 16/32/64, STAGES 1/2/3.

Source files
------------

// File: rtl/itof_pipe_pkg.sv
// Shared types and helpers for the integer to binary32 conversion pipeline.
// Holds the rounding-mode encoding, binary32 field widths and round decision.
package itof_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,
        RTZ = 2'b01,
        RDN = 2'b10,
        RUP = 2'b11
    } rm_e;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int BIAS  = 127;

    // guard is the first dropped bit; sticky is the OR of all bits below it
    function automatic logic round_inc(
        input logic lsb,
        input logic guard,
        input logic sticky,
        input logic sign,
        input rm_e  rm
    );
        logic inc;
        inc = 1'b0;
        unique case (rm)
            RNE:     inc = guard & (sticky | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = ~sign & (guard | sticky);
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/itof_pipe_if.sv
// Operand/result handshake bundle of the itof pipeline.
// master = producer/consumer side, slave = the converter.
interface itof_pipe_if #(
    parameter int IN_WIDTH = 32
) ();

    logic                in_valid;
    logic                in_ready;
    logic [IN_WIDTH-1:0] x;
    logic                is_unsigned;
    logic [1:0]          rm;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         y;
    logic                inexact;

    modport master (
        output in_valid,
        output x,
        output is_unsigned,
        output rm,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  y,
        input  inexact
    );

    modport slave (
        input  in_valid,
        input  x,
        input  is_unsigned,
        input  rm,
        input  out_ready,
        output in_ready,
        output out_valid,
        output y,
        output inexact
    );

endinterface

// File: rtl/itof_pipe_lzc.sv
// Leading-zero counter: count of zeros above the highest set bit.
// An all-zero input reports W and raises o_zero.
module lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]           i_a,
    output logic [$clog2(W+1)-1:0] o_cnt,
    output logic                   o_zero
);

    localparam int CW = $clog2(W + 1);

    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_a[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

    assign o_zero = ~|i_a;

endmodule

// File: rtl/itof_pipe.sv
// Elastic integer to IEEE-754 binary32 converter with 1..3 register stages.
// Stage split: sign/abs/lzc | normalise | round/pack into the output reg.
module itof_pipe
    import itof_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int STAGES   = 2
) (
    input logic        clk,
    input logic        rst,
    itof_pipe_if.slave bus
);

    localparam int W     = IN_WIDTH;
    localparam int LZW   = $clog2(W + 1);
    localparam int EXT_W = W + 26;
    localparam int SUM_W = SIG_W + 1;

    typedef struct packed {
        logic           sign;
        logic           zero;
        logic [W-1:0]   mag;
        logic [LZW-1:0] lz;
        rm_e            rm;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             guard;
        logic             sticky;
        rm_e              rm;
    } s2_t;

    logic w_rdy1;
    logic w_rdy2;
    logic w_rdyo;

    logic           w_neg;
    logic [W-1:0]   w_mag;
    logic [LZW-1:0] w_lz;
    logic           w_zero;
    s1_t            w_a;

    // Magnitude kept in W bits: -2^(W-1) maps to 2^(W-1) unsigned
    assign w_neg = ~bus.is_unsigned & bus.x[W-1];
    assign w_mag = w_neg ? ((~bus.x) + W'(1)) : bus.x;

    lzc #(
        .W(W)
    ) u_lzc (
        .i_a   (w_mag),
        .o_cnt (w_lz),
        .o_zero(w_zero)
    );

    always_comb begin
        w_a.sign = w_neg;
        w_a.zero = w_zero;
        w_a.mag  = w_mag;
        w_a.lz   = w_lz;
        w_a.rm   = rm_e'(bus.rm);
    end

    s1_t  w_b_in;
    logic w_b_v;

    generate
        if (STAGES >= 2) begin : g_s1
            logic r_v1;
            s1_t  r_p1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v1 <= 1'b0;
                end else if (w_rdy1) begin
                    r_v1 <= bus.in_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (w_rdy1 && bus.in_valid) begin
                    r_p1 <= w_a;
                end
            end

            assign w_b_in = r_p1;
            assign w_b_v  = r_v1;
            assign w_rdy1 = ~r_v1 | w_rdy2;
        end else begin : g_s1_byp
            assign w_b_in = w_a;
            assign w_b_v  = bus.in_valid;
            assign w_rdy1 = w_rdy2;
        end
    endgenerate

    logic [W-1:0]     w_norm;
    logic [EXT_W-1:0] w_ext;
    s2_t              w_b;

    // Leading one lands at the top of w_ext; 26 pad bits feed guard/sticky
    always_comb begin
        w_norm     = w_b_in.mag << w_b_in.lz;
        w_ext      = {w_norm, 26'd0};
        w_b.sign   = w_b_in.sign;
        w_b.zero   = w_b_in.zero;
        w_b.exp    = EXP_W'(BIAS + W - 1) - EXP_W'(w_b_in.lz);
        w_b.sig    = w_ext[EXT_W-1 -: SIG_W];
        w_b.guard  = w_ext[W+1];
        w_b.sticky = |w_ext[W:0];
        w_b.rm     = w_b_in.rm;
    end

    s2_t  w_c_in;
    logic w_c_v;

    generate
        if (STAGES >= 3) begin : g_s2
            logic r_v2;
            s2_t  r_p2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                end else if (w_rdy2) begin
                    r_v2 <= w_b_v;
                end
            end

            always_ff @(posedge clk) begin
                if (w_rdy2 && w_b_v) begin
                    r_p2 <= w_b;
                end
            end

            assign w_c_in = r_p2;
            assign w_c_v  = r_v2;
            assign w_rdy2 = ~r_v2 | w_rdyo;
        end else begin : g_s2_byp
            assign w_c_in = w_b;
            assign w_c_v  = w_b_v;
            assign w_rdy2 = w_rdyo;
        end
    endgenerate

    logic             w_inc;
    logic [SUM_W-1:0] w_sum;
    logic [EXP_W-1:0] w_exp;
    logic [MAN_W-1:0] w_man;
    logic [31:0]      w_y;
    logic             w_inx;

    // A carry out of the significand bumps the exponent
    always_comb begin
        w_inc = round_inc(w_c_in.sig[0], w_c_in.guard,
                          w_c_in.sticky, w_c_in.sign,
                          w_c_in.rm);
        w_sum = {1'b0, w_c_in.sig} + SUM_W'(w_inc);
        w_exp = w_c_in.exp + EXP_W'(w_sum[SIG_W]);
        w_man = w_sum[SIG_W] ? w_sum[SIG_W-1:1]
                             : w_sum[MAN_W-1:0];
        w_inx = w_c_in.guard | w_c_in.sticky;
        w_y   = w_c_in.zero ? 32'd0
                            : {w_c_in.sign, w_exp, w_man};
    end

    logic        r_vo;
    logic [31:0] r_y;
    logic        r_inx;

    assign w_rdyo = ~r_vo | bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vo  <= 1'b0;
            r_y   <= 32'd0;
            r_inx <= 1'b0;
        end else if (w_rdyo) begin
            r_vo <= w_c_v;
            if (w_c_v) begin
                r_y   <= w_y;
                r_inx <= w_inx;
            end
        end
    end

    assign bus.in_ready  = w_rdy1 & ~rst;
    assign bus.out_valid = r_vo;
    assign bus.y         = r_y;
    assign bus.inexact   = r_inx;

endmodule
